// File: rtl/matrix_scan_driver.sv
// Row-multiplexed driver for an 8x8 red/green LED matrix with per-row blanking and per-frame snapshot.
// Optional PWM dimming of the column lines when MATRIX_SCAN_DIM_EN is defined.
module matrix_scan_driver #(
    parameter int DWELL = 12500,
    parameter int BLANK = 250
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
`ifdef MATRIX_SCAN_DIM_EN
    input  logic [3:0]   dim,
`endif
    input  logic [127:0] matrix_data,
    output logic [7:0]   row_sel,
    output logic [7:0]   col_r,
    output logic [7:0]   col_g,
    output logic         frame_start
);
    localparam int NROWS = 8;
    localparam int NCOLS = 8;
    localparam int MAXN  = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW    = (MAXN > 1) ? $clog2(MAXN) : 1;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

    typedef struct packed {
        logic [NROWS-1:0] row_sel;
        logic [NCOLS-1:0] col_r;
        logic [NCOLS-1:0] col_g;
        logic             frame_start;
    } drive_t;

    state_t                 state_q, state_d;
    logic [2:0]             row_q, row_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   cap;
    logic [NROWS-1:0][15:0] frame_q, frame_d;
    logic [15:0]            row_bits;
    logic [NCOLS-1:0]       col_r_d, col_g_d;
    logic                   show_d, lit_d;
    drive_t                 drv_q, drv_d;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = cnt_q + CW'(1);
        cap     = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (en) begin
                    state_d = S_BLANK;
                    row_d   = '0;
                    cap     = 1'b1;
                end
            end
            S_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = S_SHOW;
                    cnt_d   = '0;
                end
            end
            S_SHOW: begin
                if (cnt_q == DWELL_LAST) begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                    row_d   = row_q + 3'd1;
                    cap     = (row_q == 3'd7);
                end
            end
            default: begin
                state_d = S_IDLE;
                row_d   = '0;
                cnt_d   = '0;
            end
        endcase
        // Disable wins over everything, including a pending capture.
        if (!en) begin
            state_d = S_IDLE;
            row_d   = '0;
            cnt_d   = '0;
            cap     = 1'b0;
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    assign frame_d  = cap ? matrix_data : frame_q;
    assign row_bits = frame_d[row_d];
    assign show_d   = (state_d == S_SHOW);

    for (genvar c = 0; c < NCOLS; c++) begin : g_col
        assign col_r_d[c] = row_bits[2*c];
        assign col_g_d[c] = row_bits[2*c+1];
    end

`ifdef MATRIX_SCAN_DIM_EN
    logic [3:0] phase_q, phase_d;
    assign phase_d = (state_q == S_SHOW) ? phase_q + 4'd1 : 4'd0;
    assign lit_d   = show_d && (phase_d <= dim);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) phase_q <= '0;
        else     phase_q <= show_d ? phase_d : 4'd0;
    end
`else
    assign lit_d = show_d;
`endif

    always_comb begin
        drv_d             = '0;
        drv_d.row_sel     = show_d ? (8'd1 << row_d) : 8'd0;
        drv_d.col_r       = lit_d ? col_r_d : 8'd0;
        drv_d.col_g       = lit_d ? col_g_d : 8'd0;
        drv_d.frame_start = cap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            cnt_q   <= '0;
            frame_q <= '0;
            drv_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            drv_q   <= drv_d;
        end
    end

    assign row_sel     = drv_q.row_sel;
    assign col_r       = drv_q.col_r;
    assign col_g       = drv_q.col_g;
    assign frame_start = drv_q.frame_start;
endmodule

// File: tb/tb_matrix_scan_driver.sv
// Bench for matrix_scan_driver: frame-period model checked every cycle plus hand-computed spot checks.
module tb_matrix_scan_driver;
`ifdef MATRIX_SCAN_DIM_EN
    localparam int D = 32;
`else
    localparam int D = 4;
`endif
    localparam int B  = 2;
    localparam int RP = B + D;
    localparam int P  = 8 * RP;

    logic         clk = 1'b0;
    logic         clk_run = 1'b1;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic [127:0] md = '0;
    logic [7:0]   row_sel, col_r, col_g;
    logic         frame_start;
`ifdef MATRIX_SCAN_DIM_EN
    logic [3:0]   dim = 4'd15;
`endif

    int tests = 0;
    int fails = 0;
    int pe = 0;
    int base = 0;

    matrix_scan_driver #(.DWELL(D), .BLANK(B)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
`ifdef MATRIX_SCAN_DIM_EN
        .dim(dim),
`endif
        .matrix_data(md),
        .row_sel(row_sel),
        .col_r(col_r),
        .col_g(col_g),
        .frame_start(frame_start)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    always @(posedge clk) pe++;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: position within the scan is just elapsed cycles modulo the frame period.
    logic         m_act = 1'b0;
    int           m_t = 0;
    logic [127:0] m_frame = '0;
    int           m_dim = 15;

    always @(posedge clk or posedge rst) begin
        if (rst) m_act = 1'b0;
        else if (!en) m_act = 1'b0;
        else if (!m_act) begin
            m_act = 1'b1;
            m_t = 0;
            m_frame = md;
        end else begin
            m_t++;
            if (m_t % P == 0) m_frame = md;
        end
`ifdef MATRIX_SCAN_DIM_EN
        m_dim = int'(dim);
`endif
    end

    always @(negedge clk) begin
        logic [7:0]  e_rs, e_r, e_g, e_fs;
        logic [15:0] rb;
        int p, row, q;
        e_rs = '0; e_r = '0; e_g = '0; e_fs = '0;
        if (m_act) begin
            p   = m_t % P;
            row = p / RP;
            q   = p % RP;
            e_fs[0] = (p == 0);
            if (q >= B) begin
                e_rs[row] = 1'b1;
                rb = m_frame[row*16 +: 16];
                for (int c = 0; c < 8; c++) begin
                    e_r[c] = rb[2*c];
                    e_g[c] = rb[2*c+1];
                end
                if (((q - B) % 16) > m_dim) begin
                    e_r = '0;
                    e_g = '0;
                end
            end
        end
        chk("model row_sel", row_sel, e_rs);
        chk("model col_r", col_r, e_r);
        chk("model col_g", col_g, e_g);
        chk("model frame_start", {7'd0, frame_start}, e_fs);
    end

    task automatic at(input int c);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while ((pe - base < c) && (guard < 5000));
        if (guard >= 5000) begin
            tests++;
            fails++;
            $display("FAIL wait budget: cycle %0d not reached", c);
        end
    endtask

    task automatic start();
        en = 1'b1;
        base = pe + 1;
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset row_sel", row_sel, 8'h00);
        chk("reset col_r", col_r, 8'h00);
        chk("reset frame_start", {7'd0, frame_start}, 8'h00);
        rst = 1'b0;
        @(negedge clk);

        // single pixel r0c0, red+green
        md = 128'h3;
        start();
        at(0);      chk("f0 frame_start", {7'd0, frame_start}, 8'h01);
                    chk("f0 dark0", row_sel, 8'h00);
        at(1);      chk("f0 fs one cycle", {7'd0, frame_start}, 8'h00);
                    chk("f0 dark1", row_sel, 8'h00);
        at(B);      chk("r0 row_sel", row_sel, 8'h01);
                    chk("r0 col_r", col_r, 8'h01);
                    chk("r0 col_g", col_g, 8'h01);
        at(RP - 1); chk("r0 last lit", row_sel, 8'h01);
        at(RP);     chk("r1 blank", row_sel, 8'h00);
        at(RP + B); chk("r1 row_sel", row_sel, 8'h02);
                    chk("r1 col_r", col_r, 8'h00);
        md = 128'd1 << 114;
        at(P - 1);  chk("fs not early", {7'd0, frame_start}, 8'h00);
        at(P);      chk("f1 frame_start", {7'd0, frame_start}, 8'h01);

        // row 7 col 1 red, then wrap
        at(P + 7*RP + B); chk("r7 row_sel", row_sel, 8'h80);
                          chk("r7 col_r", col_r, 8'h02);
                          chk("r7 col_g", col_g, 8'h00);
        md = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        at(2*P);    chk("wrap frame_start", {7'd0, frame_start}, 8'h01);
                    chk("wrap dark", row_sel, 8'h00);

        // tear-free: new data mid-frame stays invisible
        at(2*P + 2*RP + B + 1); md = '1;
        at(2*P + 5*RP + B); chk("tear r5 row_sel", row_sel, 8'h20);
                            chk("tear r5 col_r", col_r, 8'h11);
                            chk("tear r5 col_g", col_g, 8'hAF);
        at(3*P + B);        chk("new r0 col_r", col_r, 8'hFF);
                            chk("new r0 col_g", col_g, 8'hFF);

        // disable during row 3
        at(3*P + 3*RP + B); chk("r3 row_sel", row_sel, 8'h08);
        en = 1'b0;
        at(3*P + 3*RP + B + 1); chk("dis row_sel", row_sel, 8'h00);
                                chk("dis col_r", col_r, 8'h00);
        at(3*P + 3*RP + B + 3);
        start();
        at(0);      chk("re frame_start", {7'd0, frame_start}, 8'h01);
        at(B);      chk("re r0 row_sel", row_sel, 8'h01);
                    chk("re r0 col_g", col_g, 8'hFF);

`ifdef MATRIX_SCAN_DIM_EN
        dim = 4'd3;
        at(RP + B + 3);  chk("dim ph3", col_r, 8'hFF);
        at(RP + B + 4);  chk("dim ph4", col_g, 8'h00);
                         chk("dim row held", row_sel, 8'h02);
        at(RP + B + 16); chk("dim ph0 again", col_r, 8'hFF);
        at(RP + B + 31); chk("dim last row", row_sel, 8'h02);
        dim = 4'd15;
`endif

        // async reset mid-SHOW with the clock stopped
        at(P + B + 1);
        chk("pre-rst row_sel", row_sel, 8'h01);
        clk_run = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async row_sel", row_sel, 8'h00);
        chk("async col_r", col_r, 8'h00);
        chk("async col_g", col_g, 8'h00);
        chk("async frame_start", {7'd0, frame_start}, 8'h00);
        en = 1'b0;
        #5 rst = 1'b0;
        #2 clk_run = 1'b1;
        @(negedge clk);
        chk("post-rst idle", row_sel, 8'h00);
        start();
        at(0);      chk("post-rst frame_start", {7'd0, frame_start}, 8'h01);
        at(B);      chk("post-rst r0 col_r", col_r, 8'hFF);
        at(B + 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/matrix_scan_driver.md
Name: matrix_scan_driver

Overview:
- Physical-side consumer of the 128-bit game frame produced by the game matrix controller.
- Time-multiplexes an 8x8 bicolor (red/green) LED dot matrix, one row at a time, with a blanking gap between rows to suppress ghosting.
- Snapshots the frame once per scan so the display never tears mid-frame.

Parameters:
DWELL, 12500, clk cycles a row is lit (SHOW); legal range >= 1
BLANK, 250, clk cycles all lines are off before each row (BLANK); legal range >= 1

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
en  input  1  scan enable; low forces display dark
matrix_data  input  128  frame. Row r is bits [16r+15:16r]. Pixel c of row r: bit 16r+2c = red, bit 16r+2c+1 = green.
row_sel  output  8  one-hot row drive, active-high, bit r = row r
col_r  output  8  red column drive, active-high, bit c = column c
col_g  output  8  green column drive, active-high
frame_start  output  1  one-cycle pulse in the first cycle of row 0 BLANK

Behaviour:
- All outputs are registered.
- On rst (asynchronous, no clock edge needed):
  - row_sel=0, col_r=0, col_g=0, frame_start=0.
  - state=IDLE, row_idx=0, counters=0, frame register=0.
- FSM states: IDLE, BLANK, SHOW.
- IDLE:
  - All outputs 0.
  - If en=1 at an edge: go to BLANK with row_idx=0.
- BLANK (row_idx = r):
  - row_sel=0, col_r=0, col_g=0.
  - Lasts exactly BLANK cycles, then SHOW.
- SHOW (row_idx = r):
  - row_sel = 1<<r.
  - col_r[c] = frame[16r+2c], col_g[c] = frame[16r+2c+1].
  - Lasts exactly DWELL cycles.
  - Then BLANK with row_idx=(r+1) mod 8. Row 7 wraps to row 0.
- Frame capture:
  - At the edge that enters BLANK with row_idx=0 (from IDLE or via wrap from row 7), the frame register loads matrix_data sampled at that edge.
  - frame_start=1 for exactly the first cycle of that BLANK.
  - matrix_data changes at any other time have no visible effect until the next capture.
- Timing: frame period = 8*(BLANK+DWELL) cycles.
  - First lit cycle of row 0 is BLANK+1 cycles after the edge that samples en=1 in IDLE.
- en=0 sampled at any edge, in any state: next state IDLE, row_idx=0, counters cleared, outputs 0 from the next cycle.
  - A later en=1 restarts at row 0 with a fresh capture and frame_start pulse.
- Never more than one row_sel bit is high.
- row_sel and the column lines change only at BLANK/SHOW boundaries, so row and column never overlap across rows.
- Dwell/blank counter width is clog2(max(DWELL,BLANK)). Count from 0 to N-1, then reset to 0 on state change.

Optional Feature:
- Macro: MATRIX_SCAN_DIM_EN.
- Defined:
  - Adds input port dim, width 4, after en.
  - A 4-bit PWM phase counter runs freely during SHOW and resets to 0 on entry to each SHOW.
  - col_r/col_g are gated to 0 in SHOW cycles where phase > dim.
  - row_sel is unaffected.
  - dim=15 gives full brightness; dim=0 lights 1 of every 16 SHOW cycles.
  - dim is sampled every cycle; no capture.
- Undefined:
  - No dim port.
  - Columns are ungated throughout SHOW, equal to the dim=15 behaviour.

Test Plan:
1. DWELL=4, BLANK=2; assert rst mid-SHOW with clk stopped -> row_sel, col_r, col_g, frame_start all 0 immediately. After release and en=1, first frame_start is 1 cycle after the en edge.
2. matrix_data=128'h3 (pixel r0c0, red+green), en=1:
   - frame_start=1 for 1 cycle.
   - 2 dark cycles, then row_sel=8'h01, col_r=8'h01, col_g=8'h01 for 4 cycles.
   - 2 dark cycles, then row_sel=8'h02, cols=0.
   - Next frame_start 48 cycles after the first.
3. matrix_data=128'h1 << 114 (row 7, col 1, red) -> during the row 7 SHOW, row_sel=8'h80, col_r=8'h02, col_g=0. Then BLANK with row 0 and frame_start=1 (wrap).
4. Tear-free: change matrix_data to all-ones during the row 2 SHOW -> rows 2..7 keep the old data; all-ones appears only after the next frame_start.
5. en=0 during the row 3 SHOW -> all outputs 0 on the next cycle. en=1 again -> frame_start, then row 0 lit after 2 BLANK cycles (rows 4..7 skipped).
6. (MATRIX_SCAN_DIM_EN, DWELL=32) dim=3, full-ones frame -> in each SHOW, columns are 8'hFF for phases 0..3 and 0 for phases 4..15, repeating. row_sel stays high for all 32 cycles.
